// File: rtl/siu_dmu_pkg.sv
// Shared types and constants for the SIU -> DMU packet transmit path.
// Holds the FSM encoding, header field layout and parity lane geometry.
package siu_dmu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DATA = 2'd3
    } state_e;

    localparam int DATA_W        = 128;
    localparam int PAYLOAD_BEATS = 4;
    localparam int PAYLOAD_W     = DATA_W * PAYLOAD_BEATS;

    localparam int CMD_MSB = 127;
    localparam int CMD_LSB = 122;
    localparam int CMD_W   = CMD_MSB - CMD_LSB + 1;
    localparam int TAG_MSB = 79;
    localparam int TAG_LSB = 64;
    localparam int TAG_W   = TAG_MSB - TAG_LSB + 1;

    localparam int PAR_LANE_W = 16;
    localparam int PAR_LANES  = DATA_W / PAR_LANE_W;

    // Header word: command and tag in their fixed fields, every other bit zero.
    function automatic logic [DATA_W-1:0] build_hdr(input logic [CMD_W-1:0] cmd,
                                                    input logic [TAG_W-1:0] tag);
        logic [DATA_W-1:0] w;
        w                  = '0;
        w[CMD_MSB:CMD_LSB] = cmd;
        w[TAG_MSB:TAG_LSB] = tag;
        return w;
    endfunction

endpackage

// File: rtl/siu_dmu_par_gen.sv
// Even parity per 16-bit lane of a 128-bit word; purely combinational.
module siu_dmu_par_gen
    import siu_dmu_pkg::*;
(
    input  logic [DATA_W-1:0]    data_i,
    output logic [PAR_LANES-1:0] par_o
);

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        par_o = '0;
        for (int i = 0; i < PAR_LANES; i++) begin
            par_o[i] = ^data_i[i*PAR_LANE_W +: PAR_LANE_W];
        end
    end

endmodule

// File: rtl/siu_dmu_pkt_tx.sv
// Credit-gated packet transmitter: one header cycle, then for data packets a
// zero gap cycle followed by four 128-bit payload beats, all outputs registered.
module siu_dmu_pkt_tx
    import siu_dmu_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic                 iol2clk,
    input  logic                 rst_l,
    input  logic                 req_vld,
    output logic                 req_rdy,
    input  logic [CMD_W-1:0]     req_cmd,
    input  logic [TAG_W-1:0]     req_tag,
    input  logic                 req_has_data,
    input  logic [PAYLOAD_W-1:0] req_data,
    input  logic                 dmu_sio_credit,
    output logic                 sio_dmu_hdr_vld,
    output logic                 sio_dmu_datareq,
    output logic [DATA_W-1:0]    sio_dmu_data,
    output logic [PAR_LANES-1:0] sio_dmu_parity,
    output logic                 credit_err
);

    localparam logic [3:0] CREDIT_MAX = 4'(CREDITS);
    localparam logic [1:0] LAST_BEAT  = 2'(PAYLOAD_BEATS - 1);

    state_e                 state_q, state_d;
    logic [1:0]             beat_q, beat_d;
    logic [3:0]             credit_cnt_q, credit_cnt_d;
    logic                   credit_err_q, credit_err_d;
    logic                   has_data_q, has_data_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;

    logic                   hdr_vld_q, hdr_vld_d;
    logic                   datareq_q, datareq_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [PAR_LANES-1:0]   parity_q, parity_d;

    logic                   accept;

    assign req_rdy = (state_q == ST_IDLE) && (credit_cnt_q != 4'd0);
    assign accept  = req_vld && req_rdy;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_HDR;
            end
            ST_HDR: begin
                state_d = has_data_q ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                state_d = ST_DATA;
                beat_d  = '0;
            end
            ST_DATA: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_comb begin
        has_data_d = has_data_q;
        payload_d  = payload_q;
        if (accept) begin
            has_data_d = req_has_data;
            payload_d  = req_data;
        end
    end

    // Simultaneous take and return cancel out; a return on a full counter is
    // dropped and flagged rather than wrapping.
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;
        if (accept && !dmu_sio_credit) begin
            credit_cnt_d = credit_cnt_q - 4'd1;
        end else if (!accept && dmu_sio_credit) begin
            if (credit_cnt_q == CREDIT_MAX) begin
                credit_err_d = 1'b1;
            end else begin
                credit_cnt_d = credit_cnt_q + 4'd1;
            end
        end
    end

    // Outputs are decoded from the next state so they land in registers the
    // same edge the state does; the header comes straight from the request.
    always_comb begin
        hdr_vld_d = 1'b0;
        datareq_d = 1'b0;
        data_d    = '0;
        unique case (state_d)
            ST_HDR: begin
                hdr_vld_d = 1'b1;
                datareq_d = req_has_data;
                data_d    = build_hdr(req_cmd, req_tag);
            end
            ST_DATA: begin
                data_d = payload_q[{beat_d, 7'd0} +: DATA_W];
            end
            default: begin
                data_d = '0;
            end
        endcase
    end

    siu_dmu_par_gen u_par_gen (
        .data_i (data_d),
        .par_o  (parity_d)
    );

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            credit_cnt_q <= CREDIT_MAX;
            credit_err_q <= 1'b0;
            has_data_q   <= 1'b0;
            hdr_vld_q    <= 1'b0;
            datareq_q    <= 1'b0;
            data_q       <= '0;
            parity_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
            has_data_q   <= has_data_d;
            hdr_vld_q    <= hdr_vld_d;
            datareq_q    <= datareq_d;
            data_q       <= data_d;
            parity_q     <= parity_d;
        end
    end

    // NOTE: the payload store is deliberately left out of reset; it is only
    // read in DATA, which is reachable solely after an accept has loaded it.
    always_ff @(posedge iol2clk) begin
        payload_q <= payload_d;
    end

    assign sio_dmu_hdr_vld = hdr_vld_q;
    assign sio_dmu_datareq = datareq_q;
    assign sio_dmu_data    = data_q;
    assign sio_dmu_parity  = parity_q;
    assign credit_err      = credit_err_q;

endmodule

// File: tb/tb_siu_dmu_pkt_tx.sv
// Scoreboarded bench for siu_dmu_pkt_tx: a driver with a credit/occupancy model
// queues expected packets, a monitor pops them whenever a header appears.
module tb_siu_dmu_pkt_tx;

    localparam int CREDITS = 4;

    typedef struct {
        logic [5:0]   cmd;
        logic [15:0]  tag;
        logic         has_data;
        logic [511:0] data;
    } pkt_t;

    logic         iol2clk;
    logic         rst_l;
    logic         req_vld;
    logic         req_rdy;
    logic [5:0]   req_cmd;
    logic [15:0]  req_tag;
    logic         req_has_data;
    logic [511:0] req_data;
    logic         dmu_sio_credit;
    logic         sio_dmu_hdr_vld;
    logic         sio_dmu_datareq;
    logic [127:0] sio_dmu_data;
    logic [7:0]   sio_dmu_parity;
    logic         credit_err;

    siu_dmu_pkt_tx #(.CREDITS(CREDITS)) dut (
        .iol2clk         (iol2clk),
        .rst_l           (rst_l),
        .req_vld         (req_vld),
        .req_rdy         (req_rdy),
        .req_cmd         (req_cmd),
        .req_tag         (req_tag),
        .req_has_data    (req_has_data),
        .req_data        (req_data),
        .dmu_sio_credit  (dmu_sio_credit),
        .sio_dmu_hdr_vld (sio_dmu_hdr_vld),
        .sio_dmu_datareq (sio_dmu_datareq),
        .sio_dmu_data    (sio_dmu_data),
        .sio_dmu_parity  (sio_dmu_parity),
        .credit_err      (credit_err)
    );

    initial iol2clk = 1'b0;
    always #5 iol2clk = ~iol2clk;

    int n_checks = 0;
    int n_fail   = 0;

    pkt_t pkt_q[$];

    // Reference model: outstanding credits, cycles until idle again, error flag.
    int m_cnt  = CREDITS;
    int m_busy = 0;
    bit m_err  = 1'b0;

    int           mon_left = 0;
    logic [511:0] mon_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_par(input logic [127:0] w);
        logic [7:0] p;
        p = '0;
        for (int l = 0; l < 8; l++)
            for (int b = 0; b < 16; b++)
                p[l] = p[l] ^ w[l*16 + b];
        return p;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic bit model_rdy();
        return (m_busy == 0) && (m_cnt != 0);
    endfunction

    // One clock of stimulus, entered and left just after a falling edge.
    task automatic cycle(input logic vld, input logic [5:0] cmd, input logic [15:0] tag,
                         input logic hd, input logic [511:0] data, input logic cr);
        bit   acc;
        pkt_t p;
        req_vld        = vld;
        req_cmd        = cmd;
        req_tag        = tag;
        req_has_data   = hd;
        req_data       = data;
        dmu_sio_credit = cr;
        #1;
        check("req_rdy", 128'(req_rdy), 128'(model_rdy()));
        check("credit_err", 128'(credit_err), 128'(m_err));
        acc = vld && model_rdy();
        @(posedge iol2clk);
        if (acc) begin
            p.cmd = cmd; p.tag = tag; p.has_data = hd; p.data = data;
            pkt_q.push_back(p);
        end
        if (acc && !cr)       m_cnt--;
        else if (cr && !acc) begin
            if (m_cnt == CREDITS) m_err = 1'b1;
            else                  m_cnt++;
        end
        if (acc)             m_busy = hd ? 6 : 1;
        else if (m_busy > 0) m_busy--;
        #1;
        req_vld        = 1'b0;
        req_cmd        = 6'($urandom());
        req_tag        = 16'($urandom());
        req_has_data   = 1'($urandom());
        req_data       = rand512();
        dmu_sio_credit = 1'b0;
        @(negedge iol2clk);
    endtask

    task automatic idle(input int n, input logic cr);
        for (int i = 0; i < n; i++) cycle(1'b0, 6'h0, 16'h0, 1'b0, 512'h0, cr);
    endtask

    task automatic check_outputs_zero(input string tag_name);
        check({tag_name, "_hdr_vld"}, 128'(sio_dmu_hdr_vld), 128'(0));
        check({tag_name, "_datareq"}, 128'(sio_dmu_datareq), 128'(0));
        check({tag_name, "_data"}, sio_dmu_data, 128'(0));
        check({tag_name, "_parity"}, 128'(sio_dmu_parity), 128'(0));
    endtask

    // Monitor: a header pops the next expected packet; a data packet then owes
    // one zero gap word and four beats; anything else must be an idle zero word.
    initial begin
        pkt_t         p;
        logic [127:0] exp_w;
        int           idx;
        forever begin
            @(negedge iol2clk);
            if (!rst_l) begin
                mon_left = 0;
                continue;
            end
            if (sio_dmu_hdr_vld) begin
                check("hdr_during_payload", 128'(mon_left), 128'(0));
                if (pkt_q.size() == 0) begin
                    check("unexpected_hdr", 128'(1), 128'(0));
                end else begin
                    p = pkt_q.pop_front();
                    exp_w = '0;
                    exp_w[127:122] = p.cmd;
                    exp_w[79:64]   = p.tag;
                    check("hdr_word", sio_dmu_data, exp_w);
                    check("hdr_datareq", 128'(sio_dmu_datareq), 128'(p.has_data));
                    check("hdr_parity", 128'(sio_dmu_parity), 128'(ref_par(exp_w)));
                    mon_left = p.has_data ? 5 : 0;
                    mon_data = p.data;
                end
            end else if (mon_left != 0) begin
                idx   = 5 - mon_left;
                exp_w = (idx == 0) ? 128'h0 : mon_data[(idx-1)*128 +: 128];
                check(idx == 0 ? "gap_word" : "beat_word", sio_dmu_data, exp_w);
                check("payload_datareq", 128'(sio_dmu_datareq), 128'(0));
                check("payload_parity", 128'(sio_dmu_parity), 128'(ref_par(exp_w)));
                mon_left--;
            end else begin
                check_outputs_zero("idle");
            end
        end
    end

    initial begin
        logic [511:0] d;
        rst_l          = 1'b0;
        req_vld        = 1'b0;
        req_cmd        = '0;
        req_tag        = '0;
        req_has_data   = 1'b0;
        req_data       = '0;
        dmu_sio_credit = 1'b0;

        #12;
        check_outputs_zero("reset");
        check("reset_credit_err", 128'(credit_err), 128'(0));
        check("reset_req_rdy", 128'(req_rdy), 128'(1));
        #5 rst_l = 1'b1;
        @(negedge iol2clk);

        // First edge after release accepts a no-data packet.
        cycle(1'b1, 6'h2A, 16'h1234, 1'b0, rand512(), 1'b0);
        idle(2, 1'b0);

        // Beat n is a word of repeated nibble n: zero parity on every lane.
        for (int n = 0; n < 4; n++) begin
            logic [3:0] nib;
            nib = 4'(n);
            d[n*128 +: 128] = {32{nib}};
        end
        cycle(1'b1, 6'h15, 16'hBEEF, 1'b1, d, 1'b0);
        idle(7, 1'b0);

        d = rand512();
        d[127:0] = 128'h1;
        cycle(1'b1, 6'h3F, 16'h0001, 1'b1, d, 1'b0);
        idle(7, 1'b0);

        // Refill, then drain the credits with back-to-back no-data requests.
        idle(3, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 6'(i), 16'(i), 1'b0, rand512(), 1'b0);
        cycle(1'b1, 6'h01, 16'h0A0A, 1'b0, rand512(), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 6'h02, 16'h0B0B, 1'b0, rand512(), 1'b0);

        // Accept plus return in one cycle, then overflow the counter.
        idle(1, 1'b1);
        cycle(1'b1, 6'h03, 16'h0C0C, 1'b0, rand512(), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 6'h04, 16'h0D0D, 1'b0, rand512(), 1'b0);
        idle(5, 1'b1);
        idle(3, 1'b0);

        // Reset during beat 1 aborts the packet.
        cycle(1'b1, 6'h05, 16'h0E0E, 1'b1, rand512(), 1'b0);
        idle(3, 1'b0);
        #1 rst_l = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        check("async_reset_credit_err", 128'(credit_err), 128'(0));
        @(negedge iol2clk);
        @(posedge iol2clk);
        #2 rst_l = 1'b1;
        m_cnt  = CREDITS;
        m_busy = 0;
        m_err  = 1'b0;
        pkt_q.delete();
        @(negedge iol2clk);
        idle(4, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 6'h06, 16'(i), 1'b0, rand512(), 1'b0);
        idle(4, 1'b1);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 6), 6'($urandom()), 16'($urandom()),
                  1'($urandom()), rand512(), 1'($urandom_range(0, 9) < 3));
        end

        for (int i = 0; i < 20 && (pkt_q.size() != 0 || mon_left != 0); i++) idle(1, 1'b0);
        idle(1, 1'b0);
        check("drain_queue_empty", 128'(pkt_q.size()), 128'(0));
        check("drain_payload_done", 128'(mon_left), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/siu_dmu_pkt_tx.md
SIU_DMU_PKT_TX -- requirements
Module: siu_dmu_pkt_tx

Interface
REQ-001 Parameter CREDITS, default 4, meaning the maximum number of outstanding packets the DMU can accept (range 1..15).
REQ-002 Port iol2clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_l, input, 1: reset, asynchronous and active-low.
REQ-004 Port req_vld, input, 1: the request holds a valid packet.
REQ-005 Port req_rdy, output, 1: the block accepts the request this cycle.
REQ-006 Port req_cmd, input, 6: packet command/type field.
REQ-007 Port req_tag, input, 16: read tag.
REQ-008 Port req_has_data, input, 1: the packet carries a 64-byte payload.
REQ-009 Port req_data, input, 512: the payload; beat n is bits [128n+127:128n].
REQ-010 Port dmu_sio_credit, input, 1: one-cycle pulse that returns one credit.
REQ-011 Port sio_dmu_hdr_vld, output, 1: this cycle is a header cycle.
REQ-012 Port sio_dmu_datareq, output, 1: a payload follows the current header.
REQ-013 Port sio_dmu_data, output, 128: header or payload word.
REQ-014 Port sio_dmu_parity, output, 8: lane parity of sio_dmu_data.
REQ-015 Port credit_err, output, 1: sticky flag, a credit was returned while the counter was already full.

Function
REQ-016 req_rdy SHALL equal (state==IDLE) AND (credit_cnt!=0); it is combinational from registered state only.
REQ-017 Accept SHALL be (req_vld AND req_rdy) at a rising edge; the block then latches cmd, tag, has_data and data.
REQ-018 State machine: IDLE -> HDR on accept.
REQ-019 State machine: HDR -> GAP if has_data, else HDR -> IDLE.
REQ-020 State machine: GAP -> DATA.
REQ-021 State machine: DATA -> IDLE after beat 3; a 2-bit beat counter counts 0..3.
REQ-022 HDR cycle (the cycle after accept):
- hdr_vld=1.
- datareq=has_data.
- data[127:122]=cmd, data[79:64]=tag, all other bits 0.
REQ-023 GAP cycle: hdr_vld=0, datareq=0, data=0.
REQ-024 DATA cycles: beat n is driven in the n-th DATA cycle (n=0..3) with hdr_vld=0 and datareq=0. Beats therefore occupy header+2 .. header+5.
REQ-025 IDLE: all outputs except req_rdy and credit_err SHALL be 0.
REQ-026 Parity: sio_dmu_parity[i] SHALL equal XOR of sio_dmu_data[16i+15:16i] (even parity) in HDR and DATA cycles, and 0 otherwise.
REQ-027 All sio_dmu_* outputs SHALL be registered; the latency from accept to hdr_vld is exactly 1 cycle.
REQ-028 Throughput limits:
- A no-data packet can be accepted at most every 2 cycles.
- A data packet can be accepted at most every 7 cycles (accept, HDR, GAP, 4 beats).
REQ-029 Credit counter (4 bits) rules:
- Decrements by 1 on accept.
- Increments by 1 on dmu_sio_credit.
- Both in the same cycle: unchanged.
REQ-030 A credit pulse with credit_cnt==CREDITS and no simultaneous accept SHALL leave the counter at CREDITS and set credit_err.
REQ-031 With credit_cnt==0, req_rdy=0; a credit pulse in that cycle makes req_rdy=1 in the next cycle.
REQ-032 Request inputs SHALL be ignored outside accept; changes to req_data after accept SHALL NOT affect beats.

Reset
REQ-033 rst_l low SHALL asynchronously force the following values:
- state=IDLE, beat=0.
- credit_cnt=CREDITS, credit_err=0.
- all sio_dmu_* outputs 0.
REQ-034 Reset asserted mid-packet SHALL abort the packet; no further beats are driven after release.
REQ-035 The first accept after reset release is permitted on the first rising edge with rst_l high.

Structure
REQ-036 Shared package siu_dmu_pkg SHALL hold:
- the state enum;
- PAYLOAD_BEATS=4;
- the header field positions (CMD_MSB=127, CMD_LSB=122, TAG_MSB=79, TAG_LSB=64);
- the parity lane width 16.
REQ-037 One combinational sub-module, siu_dmu_par_gen (128-bit in, 8-bit out), SHALL be instantiated for parity.

Verification
REQ-038 Reset, then no-data request (cmd=6'h2A, tag=16'h1234). Required response:
- hdr_vld=1 one cycle after accept.
- data[127:122]=2A, data[79:64]=1234.
- datareq=0.
- idle in the next cycle.
REQ-039 Data request, req_data beat n = {32{4'hn}}. Required response:
- datareq=1 with the header.
- Zero gap cycle.
- Beats 0,1,2,3 at header+2..+5.
- parity=8'h00 for every beat (even nibble count per lane).
REQ-040 Payload word 128'h1 as beat 0 -> parity=8'h01; req_data changed after accept -> the driven beats are unaffected.
REQ-041 CREDITS=4: four no-data accepts with no returns -> req_rdy=0. One credit pulse -> exactly one more accept.
REQ-042 Credit edge cases:
- Accept and credit pulse in the same cycle -> count unchanged.
- Credit pulse at a full count -> credit_err=1 and held.
REQ-043 rst_l low during beat 1 -> all outputs 0 immediately; after release, no beat 2/3 and credit_cnt=4.
